// File: rtl/display_scroller.sv
// Rotating hex message on a multiplexed common-anode 7-segment display.
// Scroll steps are edge-qualified on `right` and gated by `toggle`; segments and anodes are registered.
module display_scroller #(
    parameter int NCHAR    = 8,
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 100000
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 load,
    input  logic [4*NCHAR-1:0]   data_in,
    input  logic                 toggle,
    input  logic                 right,
    output logic [6:0]           seg,
    output logic [NDIG-1:0]      an,
    output logic [3:0]           steps,
    output logic                 busy
);

    localparam int OW = (NCHAR > 1) ? $clog2(NCHAR) : 1;
    localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [3:0]      r_mem [NCHAR];
    logic [OW-1:0]   r_offset;
    logic            r_loaded;
    logic            r_right_q;
    logic [SW-1:0]   r_scan_cnt;
    logic [DW-1:0]   r_dig;
    logic [3:0]      r_steps;
    logic [6:0]      r_seg;
    logic [NDIG-1:0] r_an;
    logic            r_busy;

    logic            w_step;
    logic            w_load;
    logic [OW-1:0]   w_idx;
    logic [3:0]      w_char;
    logic [6:0]      w_seg_dec;

    // A level-high `right` must not keep stepping, so only its rising edge counts.
    assign w_step = right & ~r_right_q & toggle;
    assign w_load = load & ~toggle;
    // NCHAR is a power of two, so the natural wrap of the add is the rotation.
    assign w_idx  = r_offset + OW'(r_dig);
    assign w_char = r_mem[w_idx];

    always_comb begin
        w_seg_dec = 7'h7F;
        case (w_char)
            4'h0: w_seg_dec = 7'b1000000;
            4'h1: w_seg_dec = 7'b1111001;
            4'h2: w_seg_dec = 7'b0100100;
            4'h3: w_seg_dec = 7'b0110000;
            4'h4: w_seg_dec = 7'b0011001;
            4'h5: w_seg_dec = 7'b0010010;
            4'h6: w_seg_dec = 7'b0000010;
            4'h7: w_seg_dec = 7'b1111000;
            4'h8: w_seg_dec = 7'b0000000;
            4'h9: w_seg_dec = 7'b0010000;
            4'hA: w_seg_dec = 7'b0001000;
            4'hB: w_seg_dec = 7'b0000011;
            4'hC: w_seg_dec = 7'b1000110;
            4'hD: w_seg_dec = 7'b0100001;
            4'hE: w_seg_dec = 7'b0000110;
            4'hF: w_seg_dec = 7'b0001110;
            default: w_seg_dec = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            // NOTE: the message buffer is small, so it is reset with the rest of the state to keep the blank/zero contract.
            for (int i = 0; i < NCHAR; i++) r_mem[i] <= 4'h0;
            r_offset   <= '0;
            r_loaded   <= 1'b0;
            r_right_q  <= 1'b0;
            r_scan_cnt <= '0;
            r_dig      <= '0;
            r_steps    <= 4'd0;
            r_seg      <= 7'h7F;
            r_an       <= '1;
            r_busy     <= 1'b0;
        end else begin
            r_right_q <= right;
            r_busy    <= toggle;

            if (w_load) begin
                for (int i = 0; i < NCHAR; i++) r_mem[i] <= data_in[4*i +: 4];
                r_offset <= '0;
                r_steps  <= 4'd0;
                r_loaded <= 1'b1;
            end else if (w_step) begin
                r_offset <= r_offset + 1'b1;
                if (r_steps != 4'd15) r_steps <= r_steps + 4'd1;
            end

            if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_dig      <= (r_dig == DW'(NDIG - 1)) ? '0 : r_dig + 1'b1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end

            // Anode and segment come from the same digit index, so they switch together.
            r_an  <= r_loaded ? ~(NDIG'(1) << r_dig) : '1;
            r_seg <= r_loaded ? w_seg_dec : 7'h7F;
        end
    end

    assign seg   = r_seg;
    assign an    = r_an;
    assign steps = r_steps;
    assign busy  = r_busy;

endmodule
